// File: rtl/param_iter_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts or rotates a selected operand by up to STEP bits per cycle.
// It reports carry and zero flags and holds the result under a valid/ack handshake.
module param_iter_shift_unit #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SRC_SEL,
  input  logic [2:0]       ALU_FUN,
  input  logic [AMT_W-1:0] SHAMT,
  input  logic             Shift_Enable,
  output logic             Shift_Ready,
  output logic [WIDTH-1:0] Shift_OUT,
  output logic             Shift_Flag,
  output logic             Carry_Flag,
  output logic             Zero_Flag,
  input  logic             Out_Ack
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] eff;
  logic [AMT_W-1:0] step_amt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] next_data;
  logic             next_carry;

  assign Shift_Ready = (state == IDLE);

  // Shifts saturate at WIDTH, rotates wrap modulo WIDTH, unused codes pass through.
  always_comb begin
    operand = SRC_SEL ? B : A;
    eff     = '0;
    case (ALU_FUN)
      3'b000, 3'b001, 3'b010: eff = (SHAMT > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : SHAMT;
      3'b011, 3'b100:         eff = SHAMT % AMT_W'(WIDTH);
      default:                eff = '0;
    endcase
    step_amt = (remaining > AMT_W'(STEP)) ? AMT_W'(STEP) : remaining;
  end

  // One cycle of work is step_amt single-bit steps; carry keeps the last bit moved out.
  always_comb begin
    next_data  = Shift_OUT;
    next_carry = Carry_Flag;
    for (int i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < step_amt) begin
        case (op)
          3'b000: begin
            next_carry = next_data[WIDTH-1];
            next_data  = {next_data[WIDTH-2:0], 1'b0};
          end
          3'b001: begin
            next_carry = next_data[0];
            next_data  = {1'b0, next_data[WIDTH-1:1]};
          end
          3'b010: begin
            next_carry = next_data[0];
            next_data  = {next_data[WIDTH-1], next_data[WIDTH-1:1]};
          end
          3'b011: begin
            next_carry = next_data[WIDTH-1];
            next_data  = {next_data[WIDTH-2:0], next_data[WIDTH-1]};
          end
          3'b100: begin
            next_carry = next_data[0];
            next_data  = {next_data[0], next_data[WIDTH-1:1]};
          end
          default: begin
            next_carry = next_carry;
            next_data  = next_data;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      op         <= '0;
      remaining  <= '0;
      Shift_OUT  <= '0;
      Shift_Flag <= 1'b0;
      Carry_Flag <= 1'b0;
      Zero_Flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Shift_Enable) begin
            Shift_OUT  <= operand;
            op         <= ALU_FUN;
            remaining  <= eff;
            Carry_Flag <= 1'b0;
            if (eff == '0) begin
              state      <= DONE;
              Shift_Flag <= 1'b1;
              Zero_Flag  <= (operand == '0);
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          Shift_OUT  <= next_data;
          Carry_Flag <= next_carry;
          remaining  <= remaining - step_amt;
          if (remaining == step_amt) begin
            state      <= DONE;
            Shift_Flag <= 1'b1;
            Zero_Flag  <= (next_data == '0);
          end
        end
        DONE: begin
          if (Out_Ack) begin
            state      <= IDLE;
            Shift_Flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_iter_shift_unit.sv
// Directed bench for param_iter_shift_unit: a STEP=1 and a STEP=4 instance share stimulus
// and are checked against hand-computed results and latencies.
module tb_param_iter_shift_unit;

  localparam int WIDTH = 16;
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] A, B;
  logic             SRC_SEL;
  logic [2:0]       ALU_FUN;
  logic [AMT_W-1:0] SHAMT;
  logic             Shift_Enable;
  logic             Out_Ack;

  logic             ready1, flag1, carry1, zero1;
  logic             ready4, flag4, carry4, zero4;
  logic [WIDTH-1:0] out1, out4;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  param_iter_shift_unit #(.WIDTH(WIDTH), .STEP(1)) dut1 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .SRC_SEL(SRC_SEL), .ALU_FUN(ALU_FUN),
    .SHAMT(SHAMT), .Shift_Enable(Shift_Enable), .Shift_Ready(ready1),
    .Shift_OUT(out1), .Shift_Flag(flag1), .Carry_Flag(carry1), .Zero_Flag(zero1),
    .Out_Ack(Out_Ack)
  );

  param_iter_shift_unit #(.WIDTH(WIDTH), .STEP(4)) dut4 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .SRC_SEL(SRC_SEL), .ALU_FUN(ALU_FUN),
    .SHAMT(SHAMT), .Shift_Enable(Shift_Enable), .Shift_Ready(ready4),
    .Shift_OUT(out4), .Shift_Flag(flag4), .Carry_Flag(carry4), .Zero_Flag(zero4),
    .Out_Ack(Out_Ack)
  );

  typedef struct {
    string            name;
    logic             src;
    logic [2:0]       fun;
    logic [WIDTH-1:0] a, b;
    logic [AMT_W-1:0] shamt;
    logic [WIDTH-1:0] out;
    logic             carry, zero;
    int               lat1, lat4;
  } vec_t;

  // Start one op, scramble the inputs after the accept edge, and count edges to Shift_Flag.
  task automatic start_and_wait(input logic src, input logic [2:0] fun, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [AMT_W-1:0] shamt,
                                output int lat1, output int lat4);
    SRC_SEL = src; ALU_FUN = fun; A = a; B = b; SHAMT = shamt;
    Shift_Enable = 1'b1;
    @(posedge CLK); #1;
    Shift_Enable = 1'b0;
    A = ~a; B = ~b; SHAMT = ~shamt; ALU_FUN = 3'b111; SRC_SEL = ~src;
    lat1 = -1; lat4 = -1;
    for (int c = 0; c < 100; c++) begin
      if (lat1 < 0 && flag1) lat1 = c;
      if (lat4 < 0 && flag4) lat4 = c;
      if (lat1 >= 0 && lat4 >= 0) break;
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_ack();
    Out_Ack = 1'b1;
    @(posedge CLK); #1;
    Out_Ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out1, flag1, carry1, zero1, ready1} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_s1 got out=%h f=%b c=%b z=%b r=%b want 0000 0 0 0 1",
               out1, flag1, carry1, zero1, ready1);
    end
    checks++;
    if ({out4, flag4, carry4, zero4, ready4} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_s4 got out=%h f=%b c=%b z=%b r=%b want 0000 0 0 0 1",
               out4, flag4, carry4, zero4, ready4);
    end
  endtask

  task automatic test_shift_ops();
    vec_t vecs[$];
    int l1, l4;
    vecs.push_back('{"sll1",   1'b0, 3'b000, 16'h8001, 16'h0000,  1, 16'h0002, 1'b1, 1'b0,  1, 1});
    vecs.push_back('{"sra_b4", 1'b1, 3'b010, 16'h1111, 16'h8000,  4, 16'hF800, 1'b0, 1'b0,  4, 1});
    vecs.push_back('{"ror17",  1'b0, 3'b100, 16'h0001, 16'h0000, 17, 16'h8000, 1'b1, 1'b0,  1, 1});
    vecs.push_back('{"sll0",   1'b0, 3'b000, 16'h0000, 16'h0000,  0, 16'h0000, 1'b0, 1'b1,  0, 0});
    vecs.push_back('{"sll31",  1'b0, 3'b000, 16'h0000, 16'h0000, 31, 16'h0000, 1'b0, 1'b1, 16, 4});
    vecs.push_back('{"sra16",  1'b0, 3'b010, 16'h8000, 16'h0000, 16, 16'hFFFF, 1'b1, 1'b0, 16, 4});
    vecs.push_back('{"rol3",   1'b0, 3'b011, 16'h8001, 16'h0000,  3, 16'h000C, 1'b0, 1'b0,  3, 1});
    vecs.push_back('{"srl5",   1'b0, 3'b001, 16'h00F3, 16'h0000,  5, 16'h0007, 1'b1, 1'b0,  5, 2});
    vecs.push_back('{"pass",   1'b0, 3'b101, 16'h1234, 16'h0000,  7, 16'h1234, 1'b0, 1'b0,  0, 0});
    vecs.push_back('{"sll20",  1'b0, 3'b000, 16'hFFFF, 16'h0000, 20, 16'h0000, 1'b1, 1'b1, 16, 4});
    vecs.push_back('{"rol16",  1'b0, 3'b011, 16'hABCD, 16'h0000, 16, 16'hABCD, 1'b0, 1'b0,  0, 0});
    vecs.push_back('{"srl16",  1'b0, 3'b001, 16'h8000, 16'h0000, 16, 16'h0000, 1'b1, 1'b1, 16, 4});
    foreach (vecs[i]) begin
      start_and_wait(vecs[i].src, vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].shamt, l1, l4);
      checks++;
      if (l1 !== vecs[i].lat1 || l4 !== vecs[i].lat4) begin
        failures++;
        $display("[TB] FAIL %s latency got s1=%0d s4=%0d want s1=%0d s4=%0d",
                 vecs[i].name, l1, l4, vecs[i].lat1, vecs[i].lat4);
      end
      checks++;
      if ({out1, carry1, zero1} !== {vecs[i].out, vecs[i].carry, vecs[i].zero}) begin
        failures++;
        $display("[TB] FAIL %s s1 got out=%h c=%b z=%b want out=%h c=%b z=%b", vecs[i].name,
                 out1, carry1, zero1, vecs[i].out, vecs[i].carry, vecs[i].zero);
      end
      checks++;
      if ({out4, carry4, zero4} !== {vecs[i].out, vecs[i].carry, vecs[i].zero}) begin
        failures++;
        $display("[TB] FAIL %s s4 got out=%h c=%b z=%b want out=%h c=%b z=%b", vecs[i].name,
                 out4, carry4, zero4, vecs[i].out, vecs[i].carry, vecs[i].zero);
      end
      do_ack();
    end
  endtask

  task automatic test_hold_done();
    int l1, l4;
    start_and_wait(1'b0, 3'b000, 16'h0001, 16'h0000, 2, l1, l4);
    for (int c = 0; c < 5; c++) begin
      A = 16'hFFFF; ALU_FUN = 3'b001; SHAMT = 5; SRC_SEL = 1'b0;
      Shift_Enable = (c % 2 == 0);
      @(posedge CLK); #1;
      checks++;
      if ({flag1, ready1, out1, carry1, zero1} !== {1'b1, 1'b0, 16'h0004, 1'b0, 1'b0} ||
          {flag4, ready4, out4, carry4, zero4} !== {1'b1, 1'b0, 16'h0004, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL hold_done c%0d got s1 f=%b r=%b out=%h s4 f=%b r=%b out=%h want f=1 r=0 out=0004",
                 c, flag1, ready1, out1, flag4, ready4, out4);
      end
    end
    // Enable is still high on the ack edge; the unit must only return to IDLE.
    Shift_Enable = 1'b1;
    do_ack();
    Shift_Enable = 1'b0;
    checks++;
    if ({flag1, ready1, out1, carry1, zero1} !== {1'b0, 1'b1, 16'h0004, 1'b0, 1'b0} ||
        {flag4, ready4, out4, carry4, zero4} !== {1'b0, 1'b1, 16'h0004, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL after_ack got s1 f=%b r=%b out=%h s4 f=%b r=%b out=%h want f=0 r=1 out=0004",
               flag1, ready1, out1, flag4, ready4, out4);
    end
    @(posedge CLK); #1;
    checks++;
    if ({flag1, ready1, flag4, ready4} !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL idle_stays got s1 f=%b r=%b s4 f=%b r=%b want f=0 r=1",
               flag1, ready1, flag4, ready4);
    end
  endtask

  task automatic test_reset_mid_shift();
    int l1, l4;
    SRC_SEL = 1'b0; ALU_FUN = 3'b000; A = 16'h00FF; SHAMT = 8;
    Shift_Enable = 1'b1;
    @(posedge CLK); #1;
    Shift_Enable = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    checks++;
    if ({out1, flag1, carry1, zero1, ready1} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1} ||
        {out4, flag4, carry4, zero4, ready4} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL mid_reset got s1 out=%h f=%b c=%b r=%b s4 out=%h f=%b c=%b r=%b want 0000 0 0 1",
               out1, flag1, carry1, ready1, out4, flag4, carry4, ready4);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    start_and_wait(1'b0, 3'b100, 16'h0003, 16'h0000, 1, l1, l4);
    checks++;
    if (l1 !== 1 || l4 !== 1 || {out1, carry1, out4, carry4} !== {16'h8001, 1'b1, 16'h8001, 1'b1}) begin
      failures++;
      $display("[TB] FAIL post_reset_op got lat=%0d/%0d s1 out=%h c=%b s4 out=%h c=%b want lat=1/1 out=8001 c=1",
               l1, l4, out1, carry1, out4, carry4);
    end
    do_ack();
  endtask

  initial begin
    RST = 1'b1; A = '0; B = '0; SRC_SEL = 1'b0; ALU_FUN = '0; SHAMT = '0;
    Shift_Enable = 1'b0; Out_Ack = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    RST = 1'b0;
    @(posedge CLK); #1;
    test_shift_ops();
    test_hold_done();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
